// File: rtl/carry_mask_if.sv
// carry_mask_if: mode-register burst fields in, column-address carry mask out.
//   AddrMode     : burst addressing mode, 0 = sequential, 1 = interleaved
//   BurstLength  : SDRAM burst-length code
//   CarryMaskOut : registered carry mask; bit i = 1 lets column bit i change
// master = mode-register side (drives burst fields, observes the mask)
// slave  = carry_mask decoder
interface carry_mask_if #(
  parameter int MASK_W = 8
);
  logic              AddrMode;
  logic [2:0]        BurstLength;
  logic [MASK_W-1:0] CarryMaskOut;

  modport master (
    output AddrMode,
    output BurstLength,
    input  CarryMaskOut
  );

  modport slave (
    input  AddrMode,
    input  BurstLength,
    output CarryMaskOut
  );
endinterface

// File: rtl/carry_mask.sv
// carry_mask: decodes the SDRAM burst length / addressing mode into the
// column-address carry mask used by the burst column counter. Carries out of
// the masked field are suppressed so the burst wraps in its aligned block.
// Ports:
//   Clk    : system clock, rising edge
//   ResetN : synchronous active-low reset, clears the mask
//   bus    : carry_mask_if.slave (AddrMode, BurstLength in; CarryMaskOut out)
// One clock of latency; MASK_W must be at least 3.
module carry_mask #(
  parameter int MASK_W = 8
) (
  input  logic          Clk,
  input  logic          ResetN,
  carry_mask_if.slave   bus
);

  localparam logic [2:0] BL1  = 3'b000;
  localparam logic [2:0] BL2  = 3'b001;
  localparam logic [2:0] BL4  = 3'b010;
  localparam logic [2:0] BL8  = 3'b011;
  localparam logic [2:0] FULL = 3'b111;

  logic [MASK_W-1:0] mask_d;
  logic [MASK_W-1:0] mask_q;

  // Codes 100-110 are reserved and fall into the default (length 1).
  // Full-page interleaved is reserved as well, so it also yields zeros;
  // bits 3 and up are only ever set for full-page sequential.
  always_comb begin
    mask_d = '0;
    case (bus.BurstLength)
      BL1:     mask_d = '0;
      BL2:     mask_d[0]   = 1'b1;
      BL4:     mask_d[1:0] = 2'b11;
      BL8:     mask_d[2:0] = 3'b111;
      FULL:    mask_d = bus.AddrMode ? '0 : '1;
      default: mask_d = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) mask_q <= '0;
    else         mask_q <= mask_d;
  end

  assign bus.CarryMaskOut = mask_q;

endmodule

// File: tb/tb_carry_mask.sv
module tb_carry_mask;
  localparam int MASK_W = 8;

  logic Clk = 1'b0;
  logic ResetN;
  int   checks = 0;
  int   failures = 0;

  carry_mask_if #(.MASK_W(MASK_W)) bus ();

  carry_mask #(.MASK_W(MASK_W)) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [MASK_W-1:0] exp);
    checks++;
    assert (bus.CarryMaskOut === exp)
      else begin
        failures++;
        $error("FAIL %s: observed=%b expected=%b", tag, bus.CarryMaskOut, exp);
      end
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit after it.
  task automatic step(input logic rst_n, input logic am, input logic [2:0] bl,
                      input string tag, input logic [MASK_W-1:0] exp);
    ResetN = rst_n;
    bus.AddrMode = am;
    bus.BurstLength = bl;
    @(posedge Clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    ResetN = 1'b0;
    bus.AddrMode = 1'b0;
    bus.BurstLength = 3'b111;
    #1;

    // reset held three edges with full-page sequential present
    step(1'b0, 1'b0, 3'b111, "reset0", 8'b00000000);
    step(1'b0, 1'b0, 3'b111, "reset1", 8'b00000000);
    step(1'b0, 1'b0, 3'b111, "reset2", 8'b00000000);
    step(1'b1, 1'b0, 3'b111, "release", 8'b11111111);

    // sequential sweep
    step(1'b1, 1'b0, 3'b000, "seq_bl1", 8'b00000000);
    step(1'b1, 1'b0, 3'b001, "seq_bl2", 8'b00000001);
    step(1'b1, 1'b0, 3'b010, "seq_bl4", 8'b00000011);
    step(1'b1, 1'b0, 3'b011, "seq_bl8", 8'b00000111);
    step(1'b1, 1'b0, 3'b100, "seq_rsv4", 8'b00000000);
    step(1'b1, 1'b0, 3'b101, "seq_rsv5", 8'b00000000);
    step(1'b1, 1'b0, 3'b110, "seq_rsv6", 8'b00000000);
    step(1'b1, 1'b0, 3'b111, "seq_full", 8'b11111111);

    // interleaved sweep
    step(1'b1, 1'b1, 3'b000, "int_bl1", 8'b00000000);
    step(1'b1, 1'b1, 3'b001, "int_bl2", 8'b00000001);
    step(1'b1, 1'b1, 3'b010, "int_bl4", 8'b00000011);
    step(1'b1, 1'b1, 3'b011, "int_bl8", 8'b00000111);
    step(1'b1, 1'b1, 3'b100, "int_rsv4", 8'b00000000);
    step(1'b1, 1'b1, 3'b101, "int_rsv5", 8'b00000000);
    step(1'b1, 1'b1, 3'b110, "int_rsv6", 8'b00000000);
    step(1'b1, 1'b1, 3'b111, "int_full", 8'b00000000);

    // latency: new code must not show until the next edge
    step(1'b1, 1'b0, 3'b001, "lat_pre", 8'b00000001);
    bus.BurstLength = 3'b011;
    #3;
    check("lat_hold", 8'b00000001);
    @(posedge Clk);
    #1;
    check("lat_new", 8'b00000111);

    // mode toggle on full page
    step(1'b1, 1'b0, 3'b111, "tog_seq0", 8'b11111111);
    step(1'b1, 1'b1, 3'b111, "tog_int0", 8'b00000000);
    step(1'b1, 1'b0, 3'b111, "tog_seq1", 8'b11111111);
    step(1'b1, 1'b1, 3'b111, "tog_int1", 8'b00000000);

    // mid-operation reset pulse, inputs changing during reset
    step(1'b1, 1'b0, 3'b010, "mid_pre", 8'b00000011);
    step(1'b0, 1'b0, 3'b111, "mid_rst", 8'b00000000);
    step(1'b1, 1'b0, 3'b010, "mid_post", 8'b00000011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=no_finish expected=finish");
    $fatal(1, "timeout");
  end
endmodule
